pc_sequencer: RTL

Parametrised next-generation program counter for the RV32IM core: holds the fetch PC, advances on an instruction-memory ready/valid handshake, and selects the next PC by fixed priority among trap vector, resolved branch/jump redirect, return-address-stack prediction and sequential increment. It sits at the head of the fetch stage, fed by the execute-stage branch unit, the trap controller and the fetch predecoder. It also flags misaligned redirect targets.

---
 rtl/pc_pkg.sv | 19 +
 rtl/return_address_stack.sv | 82 ++++++++
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch program-counter sequencer.
//   pc_sel_e             - next-PC source chosen by the priority mux
//   INSTR_BYTES          - sequential fetch increment
//   DEFAULT_RESET_VECTOR - PC held while in reset unless overridden
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEL_HOLD,
        PC_SEL_SEQ,
        PC_SEL_RAS,
        PC_SEL_REDIRECT,
        PC_SEL_TRAP
    } pc_sel_e;

    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address predictor stack.
//   Clk_Core  in   core clock
//   Rst_Core  in   asynchronous active-high reset (discards all entries)
//   Push      in   push Push_Data
//   Pop       in   pop the top entry (ignored when empty)
//   Clear     in   drop all entries; wins over Push/Pop
//   Push_Data in   return address to push
//   Top       out  current top entry
//   Empty     out  no entries held
// Push and Pop together replace the top entry in place. A push when full
// overwrites the oldest entry, so the count saturates at RAS_DEPTH.
module return_address_stack
    import pc_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned DWIDTH    = 32
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic              Push,
    input  logic              Pop,
    input  logic              Clear,
    input  logic [DWIDTH-1:0] Push_Data,
    output logic [DWIDTH-1:0] Top,
    output logic              Empty
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [DWIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr_q, top_ptr_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en;
    logic              pop_eff;

    assign Empty   = (count_q == '0);
    assign Top     = stack_q[top_ptr_q];
    assign pop_eff = Pop & ~Empty;

    always_comb begin
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_ptr    = top_ptr_q;
        if (Clear) begin
            count_d = '0;
        end else if (Push && pop_eff) begin
            // Return consumed and a call made in the same fetch: swap top.
            wr_en = 1'b1;
        end else if (Push) begin
            top_ptr_d = top_ptr_q + PTR_W'(1);
            wr_ptr    = top_ptr_d;
            wr_en     = 1'b1;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_eff) begin
            top_ptr_d = top_ptr_q - PTR_W'(1);
            count_d   = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible below a nonzero count.
    always_ff @(posedge Clk_Core) begin
        if (wr_en) begin
            stack_q[wr_ptr] <= Push_Data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with prioritised next-PC selection.
//   Clk_Core            in   core clock
//   Rst_Core            in   asynchronous active-high reset
//   Run                 in   global enable; 0 freezes all state
//   Stall               in   blocks sequential/RAS advance only
//   Redirect_Valid      in   resolved branch/jump taken
//   Redirect_Target     in   redirect address
//   Trap_Valid          in   trap entry
//   Trap_Vector         in   trap handler address
//   Call_Push           in   current fetch is a call
//   Ret_Predict         in   current fetch is a return
//   Fetch_Ready         in   instruction memory accepts current PC
//   Fetch_Valid         out  current PC is a valid fetch request
//   Program_Count       out  current fetch PC
//   Program_Count_Plus4 out  Program_Count + 4
//   Misaligned_Err      out  one-cycle pulse on a rejected target
//   Misaligned_Addr     out  last rejected target
//   Ras_Empty           out  return-address stack holds no entries
// Priority: trap > redirect > RAS-predicted return > sequential > hold.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = DWIDTH'(DEFAULT_RESET_VECTOR),
    parameter int unsigned       RAS_DEPTH    = 4,
    parameter int unsigned       ALIGN_BITS   = 2
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic              Run,
    input  logic              Stall,
    input  logic              Redirect_Valid,
    input  logic [DWIDTH-1:0] Redirect_Target,
    input  logic              Trap_Valid,
    input  logic [DWIDTH-1:0] Trap_Vector,
    input  logic              Call_Push,
    input  logic              Ret_Predict,
    input  logic              Fetch_Ready,
    output logic              Fetch_Valid,
    output logic [DWIDTH-1:0] Program_Count,
    output logic [DWIDTH-1:0] Program_Count_Plus4,
    output logic              Misaligned_Err,
    output logic [DWIDTH-1:0] Misaligned_Addr,
    output logic              Ras_Empty
);

    localparam logic [DWIDTH-1:0] ALIGN_MASK = DWIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] pc_plus4;
    logic [DWIDTH-1:0] err_addr_q, err_addr_d;
    logic [DWIDTH-1:0] ras_top;
    logic              started_q, started_d;
    logic              err_q, err_d;
    logic              handshake;
    logic              trap_misaligned;
    logic              redirect_misaligned;
    logic              ras_push, ras_pop, ras_clear, ras_empty;
    pc_sel_e           pc_sel;

    assign pc_plus4            = pc_q + DWIDTH'(INSTR_BYTES);
    assign Fetch_Valid         = started_q & Run & ~Stall;
    assign handshake           = Fetch_Valid & Fetch_Ready;
    assign trap_misaligned     = |(Trap_Vector & ALIGN_MASK);
    assign redirect_misaligned = |(Redirect_Target & ALIGN_MASK);

    assign Program_Count       = pc_q;
    assign Program_Count_Plus4 = pc_plus4;
    assign Misaligned_Err      = err_q;
    assign Misaligned_Addr     = err_addr_q;
    assign Ras_Empty           = ras_empty;

    // Trap and redirect ignore Stall/handshake/Started; only Run gates them.
    always_comb begin
        pc_sel = PC_SEL_HOLD;
        if (Run) begin
            if (Trap_Valid) begin
                pc_sel = PC_SEL_TRAP;
            end else if (Redirect_Valid) begin
                pc_sel = PC_SEL_REDIRECT;
            end else if (handshake && Ret_Predict && !ras_empty) begin
                pc_sel = PC_SEL_RAS;
            end else if (handshake) begin
                pc_sel = PC_SEL_SEQ;
            end
        end
    end

    // A misaligned trap/redirect still wins priority (so the fetch is treated
    // as wrong-path), but loads nothing and leaves the stack untouched.
    always_comb begin
        pc_d       = pc_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_clear  = 1'b0;
        started_d  = started_q | Run;
        unique case (pc_sel)
            PC_SEL_TRAP: begin
                if (trap_misaligned) begin
                    err_d      = 1'b1;
                    err_addr_d = Trap_Vector;
                end else begin
                    pc_d      = Trap_Vector;
                    ras_clear = 1'b1;
                end
            end
            PC_SEL_REDIRECT: begin
                if (redirect_misaligned) begin
                    err_d      = 1'b1;
                    err_addr_d = Redirect_Target;
                end else begin
                    pc_d = Redirect_Target;
                end
            end
            PC_SEL_RAS: begin
                pc_d     = ras_top;
                ras_pop  = 1'b1;
                ras_push = Call_Push;
            end
            PC_SEL_SEQ: begin
                pc_d     = pc_plus4;
                ras_push = Call_Push;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            pc_q       <= RESET_VECTOR;
            started_q  <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            started_q  <= started_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    return_address_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .DWIDTH    (DWIDTH)
    ) u_ras (
        .Clk_Core  (Clk_Core),
        .Rst_Core  (Rst_Core),
        .Push      (ras_push),
        .Pop       (ras_pop),
        .Clear     (ras_clear),
        .Push_Data (pc_plus4),
        .Top       (ras_top),
        .Empty     (ras_empty)
    );

endmodule
